riscv_imem_loader: RTL and testbench
====================================

RISCV_IMEM_LOADER -- requirements
Module: riscv_imem_loader

Interface
REQ-001 SHALL have parameter AW, default 10: imem word-address width; capacity is 2**AW words.
REQ-002 SHALL have port i_clk, input, 1: single clock for all state.
REQ-003 SHALL have port i_rstn, input, 1: reset, asynchronous, active-low.
REQ-004 SHALL have port i_ld_valid, input, 1: an incoming load byte is valid.
REQ-005 SHALL have port i_ld_byte, input, 8: load stream byte.
REQ-006 SHALL have port o_ld_ready, output, 1: the loader accepts a byte this cycle.
REQ-007 SHALL have port i_restart, input, 1: return from DONE/ERR to a new load.
REQ-008 SHALL have port o_imem_wr_en, output, 1: one-cycle imem word write strobe.
REQ-009 SHALL have port o_imem_wr_addr, output, AW: imem word address.
REQ-010 SHALL have port o_imem_wr_data, output, `XLEN: imem write word.
REQ-011 SHALL have port o_cpu_rstn, output, 1: CPU reset; low until the load completes.
REQ-012 SHALL have port o_ld_done, output, 1: load completed with a good checksum.
REQ-013 SHALL have port o_ld_err, output, 1: load aborted.

Function
REQ-014 SHALL accept a byte only when i_ld_valid and o_ld_ready are both 1.
REQ-015 SHALL take the stream format: count low byte, count high byte (16-bit word count N), 4*N data bytes (little-endian per word), then one checksum byte.
REQ-016 SHALL use FSM states LEN0, LEN1, DATA, CSUM, DONE, ERR, with LEN0 as the reset state.
REQ-017 SHALL set o_ld_ready=1 in LEN0, LEN1, DATA and CSUM, and o_ld_ready=0 in DONE and ERR.
REQ-018 SHALL transition LEN0->LEN1 on a byte, and from LEN1 go to ERR if N>2**AW, to CSUM if N==0, and to DATA otherwise.
REQ-019 SHALL, in DATA, assemble bytes into bits [7:0], [15:8], [23:16], [31:24] in order of arrival.
REQ-020 SHALL, on the 4th byte of a word, drive o_imem_wr_en=1 in the next cycle, with o_imem_wr_addr equal to the word index (starting at 0) and the assembled word on o_imem_wr_data.
REQ-021 SHALL give o_imem_wr_en no backpressure; byte acceptance continues during the write cycle.
REQ-022 SHALL move DATA->CSUM after the byte that completes word N-1.
REQ-023 SHALL make the checksum the XOR of all data bytes (count bytes excluded), cleared in LEN0.
REQ-024 SHALL, in CSUM, go to DONE on a matching byte and to ERR otherwise.
REQ-025 SHALL register o_ld_done, o_ld_err and o_cpu_rstn, all asserted the cycle after the state transition.
REQ-026 SHALL drive o_cpu_rstn=1 only in DONE.
REQ-027 SHALL return DONE or ERR to LEN0 on i_restart, clearing the address, checksum and byte lane; a byte presented in the same cycle is not accepted.
REQ-028 SHALL ignore i_restart in LEN0, LEN1, DATA and CSUM.
REQ-029 SHALL compare N against 2**AW at 17-bit width, so N==2**AW is legal and fills imem exactly.
REQ-030 SHALL leave o_imem_wr_data and o_imem_wr_addr holding their last values when o_imem_wr_en=0.

Reset
REQ-031 SHALL, on i_rstn low at any time including mid-load, force state LEN0, and set o_imem_wr_en=0, o_imem_wr_addr=0, o_imem_wr_data=0, o_cpu_rstn=0, o_ld_done=0, o_ld_err=0, checksum=0 and byte lane=0.
REQ-032 SHALL make reset assertion take effect without a clock and release on the next i_clk edge.

Structure
REQ-033 SHALL place FSM state encodings and the count and checksum field widths in the shared riscv defines header, next to `XLEN and `IMEM_ADDR_BIT.
REQ-034 SHALL have a natural sub-module riscv_imem_loader_asm holding the byte-lane counter, word register and XOR accumulator; the FSM stays in the top.
REQ-035 SHALL be instantiated upstream of riscv_top, driving its imem write path, and SHALL gate i_rstn of the CPU with o_cpu_rstn.

Verification
REQ-036 SHALL cover: stream 02 00 13 00 00 00 93 00 10 00 90 -> writes addr0=0x00000013 and addr1=0x00100093, then o_ld_done=1 and o_cpu_rstn=1.
REQ-037 SHALL cover: the same stream with checksum 91 -> o_ld_err=1, o_cpu_rstn stays 0, and the two writes still occurred.
REQ-038 SHALL cover: AW=10 with count bytes 01 04 (N=1025) -> ERR one cycle after the 2nd byte, with no writes.
REQ-039 SHALL cover: stream 00 00 00 -> DONE with no o_imem_wr_en pulses; stream 00 00 05 -> ERR.
REQ-040 SHALL cover: i_rstn low after 5 data bytes -> all outputs at reset values; a new 1-word load then writes addr0.
REQ-041 SHALL cover: i_restart and i_ld_valid together in DONE -> state LEN0, byte not accepted, o_cpu_rstn=0 the next cycle.

Source files
------------

// File: rtl/riscv_imem_loader_pkg.sv
// Shared riscv defines (XLEN, imem address width, loader field widths and
// state encodings) plus the loader package built on top of them.
`ifndef RISCV_DEFINES_SVH
`define RISCV_DEFINES_SVH
`define XLEN          32
`define IMEM_ADDR_BIT 10
`define LD_CNT_W      16
`define LD_CSUM_W     8
`define LD_ST_W       3
`define LD_ST_LEN0    3'd0
`define LD_ST_LEN1    3'd1
`define LD_ST_DATA    3'd2
`define LD_ST_CSUM    3'd3
`define LD_ST_DONE    3'd4
`define LD_ST_ERR     3'd5
`endif

package riscv_imem_loader_pkg;

  localparam int LD_CNT_W  = `LD_CNT_W;
  localparam int LD_CSUM_W = `LD_CSUM_W;

  typedef enum logic [`LD_ST_W-1:0] {
    LD_LEN0 = `LD_ST_LEN0,
    LD_LEN1 = `LD_ST_LEN1,
    LD_DATA = `LD_ST_DATA,
    LD_CSUM = `LD_ST_CSUM,
    LD_DONE = `LD_ST_DONE,
    LD_ERR  = `LD_ST_ERR
  } ld_state_e;

endpackage

// File: rtl/riscv_imem_loader_asm.sv
// Byte-to-word assembler for the imem loader: byte-lane counter, partial
// word register and running XOR checksum of the data bytes.
module riscv_imem_loader_asm
  import riscv_imem_loader_pkg::*;
(
  input  logic                 i_clk,
  input  logic                 i_rstn,
  input  logic                 i_clr,
  input  logic                 i_byte_en,
  input  logic [7:0]           i_byte,
  output logic                 o_word_done,
  output logic [`XLEN-1:0]     o_word,
  output logic [LD_CSUM_W-1:0] o_csum
);

  logic [1:0]           lane_q;
  logic [23:0]          word_q;
  logic [LD_CSUM_W-1:0] csum_q;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      lane_q <= 2'd0;
      word_q <= 24'd0;
      csum_q <= '0;
    end else if (i_clr) begin
      lane_q <= 2'd0;
      word_q <= 24'd0;
      csum_q <= '0;
    end else if (i_byte_en) begin
      lane_q <= lane_q + 2'd1;
      csum_q <= csum_q ^ i_byte;
      case (lane_q)
        2'd0:    word_q[7:0]   <= i_byte;
        2'd1:    word_q[15:8]  <= i_byte;
        2'd2:    word_q[23:16] <= i_byte;
        default: word_q        <= word_q;
      endcase
    end
  end

  // The top byte is never stored: the completed word is formed combinationally
  // with the 4th byte so the top can register it on the same edge.
  assign o_word      = {i_byte, word_q};
  assign o_word_done = i_byte_en && (lane_q == 2'd3);
  assign o_csum      = csum_q;

endmodule

// File: rtl/riscv_imem_loader.sv
// Boot loader: parses a count/data/checksum byte stream into imem word writes
// and holds the CPU in reset until a load completes with a good checksum.
module riscv_imem_loader
  import riscv_imem_loader_pkg::*;
#(
  parameter int AW = `IMEM_ADDR_BIT
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_ld_valid,
  input  logic [7:0]       i_ld_byte,
  output logic             o_ld_ready,
  input  logic             i_restart,
  output logic             o_imem_wr_en,
  output logic [AW-1:0]    o_imem_wr_addr,
  output logic [`XLEN-1:0] o_imem_wr_data,
  output logic             o_cpu_rstn,
  output logic             o_ld_done,
  output logic             o_ld_err
);

  // Compared at 17 bits so a count of exactly 2**AW is accepted.
  localparam logic [LD_CNT_W:0] MAX_N = (LD_CNT_W + 1)'(1) << AW;

  ld_state_e            state_q;
  logic [LD_CNT_W-1:0]  cnt_q;
  logic [AW-1:0]        addr_q;
  logic                 wr_en_q;
  logic [AW-1:0]        wr_addr_q;
  logic [`XLEN-1:0]     wr_data_q;
  logic                 done_q;
  logic                 err_q;
  logic                 cpu_rstn_q;

  logic                 accept;
  logic                 restart_go;
  logic                 asm_clr;
  logic                 asm_byte_en;
  logic                 word_done;
  logic [`XLEN-1:0]     word;
  logic [LD_CSUM_W-1:0] csum;
  logic [LD_CNT_W-1:0]  n_full;

  always_comb begin
    o_ld_ready = 1'b0;
    case (state_q)
      LD_LEN0, LD_LEN1, LD_DATA, LD_CSUM: o_ld_ready = 1'b1;
      default:                            o_ld_ready = 1'b0;
    endcase
  end

  assign accept      = i_ld_valid && o_ld_ready;
  assign restart_go  = i_restart && ((state_q == LD_DONE) || (state_q == LD_ERR));
  assign asm_clr     = (state_q == LD_LEN0) || restart_go;
  assign asm_byte_en = accept && (state_q == LD_DATA);
  assign n_full      = {i_ld_byte, cnt_q[7:0]};

  riscv_imem_loader_asm u_asm (
    .i_clk       (i_clk),
    .i_rstn      (i_rstn),
    .i_clr       (asm_clr),
    .i_byte_en   (asm_byte_en),
    .i_byte      (i_ld_byte),
    .o_word_done (word_done),
    .o_word      (word),
    .o_csum      (csum)
  );

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q    <= LD_LEN0;
      cnt_q      <= '0;
      addr_q     <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      cpu_rstn_q <= 1'b0;
    end else begin
      wr_en_q <= 1'b0;
      case (state_q)
        LD_LEN0: begin
          addr_q <= '0;
          if (accept) begin
            cnt_q   <= {8'h00, i_ld_byte};
            state_q <= LD_LEN1;
          end
        end
        LD_LEN1: begin
          if (accept) begin
            cnt_q <= n_full;
            if ({1'b0, n_full} > MAX_N) begin
              state_q <= LD_ERR;
              err_q   <= 1'b1;
            end else if (n_full == '0) begin
              state_q <= LD_CSUM;
            end else begin
              state_q <= LD_DATA;
            end
          end
        end
        LD_DATA: begin
          if (word_done) begin
            wr_en_q   <= 1'b1;
            wr_addr_q <= addr_q;
            wr_data_q <= word;
            addr_q    <= addr_q + AW'(1);
            cnt_q     <= cnt_q - LD_CNT_W'(1);
            if (cnt_q == LD_CNT_W'(1)) state_q <= LD_CSUM;
          end
        end
        LD_CSUM: begin
          if (accept) begin
            if (i_ld_byte == csum) begin
              state_q    <= LD_DONE;
              done_q     <= 1'b1;
              cpu_rstn_q <= 1'b1;
            end else begin
              state_q <= LD_ERR;
              err_q   <= 1'b1;
            end
          end
        end
        LD_DONE, LD_ERR: begin
          if (restart_go) begin
            state_q    <= LD_LEN0;
            addr_q     <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            cpu_rstn_q <= 1'b0;
          end
        end
        default: state_q <= LD_LEN0;
      endcase
    end
  end

  assign o_imem_wr_en   = wr_en_q;
  assign o_imem_wr_addr = wr_addr_q;
  assign o_imem_wr_data = wr_data_q;
  assign o_ld_done      = done_q;
  assign o_ld_err       = err_q;
  assign o_cpu_rstn     = cpu_rstn_q;

endmodule

// File: tb/tb_riscv_imem_loader.sv
// Directed bench for riscv_imem_loader: good/bad checksum, oversize and empty
// loads, mid-load reset and restart collision.
module tb_riscv_imem_loader;

  localparam int AW = 10;

  logic          clk;
  logic          rstn;
  logic          ld_valid;
  logic [7:0]    ld_byte;
  logic          ld_ready;
  logic          restart;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data;
  logic          cpu_rstn;
  logic          ld_done;
  logic          ld_err;

  int n_checks = 0;
  int n_pass   = 0;

  logic [AW-1:0] log_addr[$];
  logic [31:0]   log_data[$];

  riscv_imem_loader #(.AW(AW)) dut (
    .i_clk          (clk),
    .i_rstn         (rstn),
    .i_ld_valid     (ld_valid),
    .i_ld_byte      (ld_byte),
    .o_ld_ready     (ld_ready),
    .i_restart      (restart),
    .o_imem_wr_en   (wr_en),
    .o_imem_wr_addr (wr_addr),
    .o_imem_wr_data (wr_data),
    .o_cpu_rstn     (cpu_rstn),
    .o_ld_done      (ld_done),
    .o_ld_err       (ld_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_en) begin
      log_addr.push_back(wr_addr);
      log_data.push_back(wr_data);
      $display("write addr=%0d data=0x%08h", wr_addr, wr_data);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
      $display("ok   %s got=0x%0h", tag, got);
    end else begin
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    ld_valid = 1'b1;
    ld_byte  = b;
    @(posedge clk);
  endtask

  task automatic idle();
    @(negedge clk);
    ld_valid = 1'b0;
    ld_byte  = 8'h00;
  endtask

  task automatic do_restart();
    @(negedge clk);
    restart = 1'b1;
    @(posedge clk);
    @(negedge clk);
    restart = 1'b0;
  endtask

  task automatic clear_log();
    log_addr.delete();
    log_data.delete();
  endtask

  task automatic send_good_prog(input logic [7:0] csum_b);
    logic [7:0] s[11];
    s = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
          8'h93, 8'h00, 8'h10, 8'h00, 8'h00};
    s[10] = csum_b;
    for (int i = 0; i < 11; i++) send(s[i]);
    idle();
  endtask

  initial begin
    rstn     = 1'b0;
    ld_valid = 1'b0;
    ld_byte  = 8'h00;
    restart  = 1'b0;
    #3;
    chk("rst_wr_en", wr_en, 0);
    chk("rst_addr", wr_addr, 0);
    chk("rst_data", wr_data, 0);
    chk("rst_cpu_rstn", cpu_rstn, 0);
    chk("rst_done", ld_done, 0);
    chk("rst_err", ld_err, 0);
    chk("rst_ready", ld_ready, 1);
    @(negedge clk);
    rstn = 1'b1;

    // Two-word program, correct checksum 0x90
    clear_log();
    send_good_prog(8'h90);
    chk("A_nwr", log_addr.size(), 2);
    if (log_addr.size() == 2) begin
      chk("A_addr0", log_addr[0], 0);
      chk("A_data0", log_data[0], 32'h00000013);
      chk("A_addr1", log_addr[1], 1);
      chk("A_data1", log_data[1], 32'h00100093);
    end
    chk("A_done", ld_done, 1);
    chk("A_err", ld_err, 0);
    chk("A_cpu_rstn", cpu_rstn, 1);
    chk("A_ready", ld_ready, 0);
    chk("A_hold_addr", wr_addr, 1);
    chk("A_hold_data", wr_data, 32'h00100093);

    // Restart colliding with a valid byte: byte must be dropped
    @(negedge clk);
    restart  = 1'b1;
    ld_valid = 1'b1;
    ld_byte  = 8'h55;
    @(posedge clk);
    @(negedge clk);
    restart  = 1'b0;
    ld_valid = 1'b0;
    chk("R_cpu_rstn", cpu_rstn, 0);
    chk("R_done", ld_done, 0);
    chk("R_ready", ld_ready, 1);

    // Empty load: if 0x55 had been taken as count low, this would not finish
    clear_log();
    send(8'h00); send(8'h00); send(8'h00);
    idle();
    chk("E_done", ld_done, 1);
    chk("E_cpu_rstn", cpu_rstn, 1);
    chk("E_nwr", log_addr.size(), 0);

    do_restart();
    send(8'h00); send(8'h00); send(8'h05);
    idle();
    chk("E5_err", ld_err, 1);
    chk("E5_done", ld_done, 0);
    chk("E5_cpu_rstn", cpu_rstn, 0);

    // Bad checksum: writes still happen, CPU stays in reset
    do_restart();
    clear_log();
    send_good_prog(8'h91);
    chk("B_err", ld_err, 1);
    chk("B_done", ld_done, 0);
    chk("B_cpu_rstn", cpu_rstn, 0);
    chk("B_nwr", log_addr.size(), 2);

    // N=1025 exceeds 2**AW
    do_restart();
    clear_log();
    send(8'h01); send(8'h04);
    idle();
    chk("O_err", ld_err, 1);
    chk("O_ready", ld_ready, 0);
    repeat (3) @(negedge clk);
    chk("O_nwr", log_addr.size(), 0);

    // N=1024 is legal; reset after 5 data bytes
    do_restart();
    send(8'h00); send(8'h04);
    idle();
    chk("M_err", ld_err, 0);
    chk("M_ready", ld_ready, 1);
    send(8'hA1); send(8'hA2); send(8'hA3); send(8'hA4); send(8'hA5);
    idle();
    #2 rstn = 1'b0;
    #1;
    chk("M_rst_wr_en", wr_en, 0);
    chk("M_rst_addr", wr_addr, 0);
    chk("M_rst_data", wr_data, 0);
    chk("M_rst_cpu_rstn", cpu_rstn, 0);
    chk("M_rst_done", ld_done, 0);
    chk("M_rst_err", ld_err, 0);
    @(negedge clk);
    rstn = 1'b1;
    clear_log();
    send(8'h01); send(8'h00);
    send(8'h78); send(8'h56); send(8'h34); send(8'h12);
    send(8'h08);
    idle();
    chk("M_nwr", log_addr.size(), 1);
    if (log_addr.size() == 1) begin
      chk("M_addr0", log_addr[0], 0);
      chk("M_data0", log_data[0], 32'h12345678);
    end
    chk("M_done", ld_done, 1);
    chk("M_cpu_rstn", cpu_rstn, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
